spsram_banked: RTL
==================

// Module: spsram_banked
// PURPOSE
//  Parametrised banked single-port SRAM subsystem. It generalises the fixed 4-bank spsram
//  tiling into one block. Provides:
//  - NUM_BANK = 2**BW_BANK banks, decoded from the address MSBs.
//  - Byte-enable writes.
//  - Pipelined reads with a valid strobe.
//  - An FSM that zero-fills every bank on request.
//  Sits between a bus adapter and the raw storage; the single shared port serves one request per cycle.
// PARAMETERS
//  BW_DATA  64  data width in bits; multiple of 8
//  BW_ADDR  6   word address width; total depth 2**BW_ADDR words
//  BW_BANK  2   bank-select width; NUM_BANK=2**BW_BANK, rows/bank=2**(BW_ADDR-BW_BANK); 1<=BW_BANK<BW_ADDR
// PORTS
//  i_clk     in   1          clock, rising edge
//  i_rstn    in   1          asynchronous active-low reset
//  i_req     in   1          request valid; accepted when i_req & o_ready
//  i_wen     in   1          1=write, 0=read (qualified by i_req)
//  i_addr    in   BW_ADDR    word address; [BW_ADDR-1 -: BW_BANK]=bank, remaining LSBs=row
//  i_data    in   BW_DATA    write data
//  i_ben     in   BW_DATA/8  byte enables; bit k covers i_data[8k+7:8k]
//  i_init    in   1          zero-fill start pulse
//  o_ready   out  1          1=IDLE and able to accept a request
//  o_rvalid  out  1          read data valid, one-cycle pulse per accepted read
//  o_data    out  BW_DATA    read data; holds last value when o_rvalid=0
//  o_busy    out  1          zero-fill in progress
// BEHAVIOUR
//  - Reset (i_rstn=0, async): FSM=IDLE, fill counter=0, o_rvalid=0, o_data=0, o_busy=0, o_ready=1.
//    Memory contents are not reset.
//  - FSM has two states.
//    - IDLE: o_ready=1. i_init=1 -> INIT at next edge.
//    - INIT: o_ready=0, o_busy=1. Each cycle writes 0 to row=cnt in ALL banks in parallel, then cnt++.
//      After row 2**(BW_ADDR-BW_BANK)-1 is written -> IDLE, cnt=0.
//      Fill takes exactly 2**(BW_ADDR-BW_BANK) cycles; o_ready rises on the edge ending the last fill cycle.
//  - Write: accepted write updates only the addressed bank/row at that edge, and only bytes with
//    i_ben=1. Other banks are untouched.
//  - Read: accepted read samples the row in the selected bank. The bank index is registered alongside
//    and drives the output mux.
//    o_data/o_rvalid appear one cycle after acceptance (latency 1).
//    Back-to-back reads sustain one result per cycle, including reads crossing bank boundaries.
//  - Read-after-write: a read of the same address accepted the cycle after a write returns the new data.
//  - A request with i_req=0 or o_ready=0 is ignored: no write, no o_rvalid.
//  - i_init together with an accepted request in IDLE: the request completes normally and INIT starts
//    next cycle. A read still returns its data during the first INIT cycle.
//  - i_init is ignored while in INIT; there is no restart.
//  - Reset mid-INIT: returns to IDLE immediately and the counter clears. Rows not yet filled keep their
//    old contents.
//  - Address range is always within the array; there is no out-of-range case, and the bank field wraps naturally.
// CONFIGURATION
//  - SPSRAM_BANKED_OREG_EN defined: adds a second output register stage. o_data/o_rvalid latency becomes
//    2 cycles and the stage resets to 0. Throughput stays 1 read/cycle.
//    Read-after-write timing and init-overlap rules are otherwise unchanged, with results shifted one cycle.
//  - SPSRAM_BANKED_OREG_EN undefined: latency 1 as above.
// TESTING (defaults: BW_DATA=64, BW_ADDR=6, BW_BANK=2)
//  1. Reset, then write addr a with data a for a=0..63 (i_ben=all 1), then read a=0..63 back-to-back
//     -> o_rvalid high for 64 consecutive cycles with o_data=a, 1 cycle after each read.
//  2. Write 0xFFFF_FFFF_FFFF_FFFF to addr 20, then write 0 with i_ben=8'h0F, then read addr 20
//     -> o_data=64'hFFFF_FFFF_0000_0000.
//  3. Reads at addr 15,16,31,32,47,48 on consecutive cycles (banks 0/1/1/2/2/3 after data=a fill)
//     -> o_data=15,16,31,32,47,48 on consecutive cycles; no bubble.
//  4. Pulse i_init after filling -> o_ready=0 and o_busy=1 for exactly 16 cycles; requests in that window
//     produce no o_rvalid and no write. Afterwards reads of 0..63 all return 0.
//  5. Assert i_rstn=0 at INIT cycle 5 (rows 0..4 cleared), then read addr 5,21,37,53 -> data 5,21,37,53
//     (old data); addr 4,20 -> 0. After reset, o_ready=1 and o_rvalid=0.
//  6. With SPSRAM_BANKED_OREG_EN defined, rerun test 1 -> first o_rvalid 2 cycles after the first read;
//     data sequence is identical.

Source files
------------

// File: rtl/spsram_banked_if.sv
// Bus bundle for spsram_banked: request/write channel, zero-fill control,
// and read-return/status signals. The master drives the i_* side, and the
// memory (slave) drives the o_* side.
interface spsram_banked_if #(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6
);
    logic                   i_req;
    logic                   i_wen;
    logic [BW_ADDR-1:0]     i_addr;
    logic [BW_DATA-1:0]     i_data;
    logic [BW_DATA/8-1:0]   i_ben;
    logic                   i_init;
    logic                   o_ready;
    logic                   o_rvalid;
    logic [BW_DATA-1:0]     o_data;
    logic                   o_busy;

    modport master (
        output i_req, i_wen, i_addr, i_data, i_ben, i_init,
        input  o_ready, o_rvalid, o_data, o_busy
    );

    modport slave (
        input  i_req, i_wen, i_addr, i_data, i_ben, i_init,
        output o_ready, o_rvalid, o_data, o_busy
    );
endinterface

// File: rtl/spsram_banked.sv
// Banked single-port SRAM with byte-enable writes, latency-1 pipelined reads,
// and a zero-fill sequencer that clears one row of every bank per cycle.
// The bank is selected by the address MSBs, and the row by the remaining LSBs.
// Optional feature macro SPSRAM_BANKED_OREG_EN adds a second output register
// stage, which makes the read latency 2 cycles.
//
// state | meaning
// IDLE  | accepting requests, o_ready=1
// INIT  | zero-filling row cnt in all banks, o_busy=1
module spsram_banked #(
    parameter int BW_DATA = 64,
    parameter int BW_ADDR = 6,
    parameter int BW_BANK = 2
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    spsram_banked_if.slave  bus
);
    localparam int NUM_BANK = 2 ** BW_BANK;
    localparam int BW_ROW   = BW_ADDR - BW_BANK;
    localparam int NUM_ROW  = 2 ** BW_ROW;
    localparam int NUM_BYTE = BW_DATA / 8;

    typedef enum logic {ST_IDLE, ST_INIT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BW_ROW-1:0]   cnt;
    logic                ready;
    logic                busy;
    logic                accept;
    logic                wr;
    logic                rd;
    logic                last_row;
    logic [BW_BANK-1:0]  bank;
    logic [BW_ROW-1:0]   row;

    logic [BW_DATA-1:0]  mem [NUM_BANK][NUM_ROW];
    logic [BW_DATA-1:0]  bank_rd [NUM_BANK];
    logic [BW_BANK-1:0]  bank_q;
    logic                rvalid_q;
    logic [BW_DATA-1:0]  rd_mux;

    assign bank     = bus.i_addr[BW_ADDR-1 -: BW_BANK];
    assign row      = bus.i_addr[BW_ROW-1:0];
    assign accept   = bus.i_req & ready;
    assign wr       = accept & bus.i_wen;
    assign rd       = accept & ~bus.i_wen;
    assign last_row = (cnt == BW_ROW'(NUM_ROW - 1));

    // State register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Next-state decision: init starts from IDLE only, and the fill ends after the last row.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.i_init) state_nxt = ST_INIT;
            ST_INIT: if (last_row)   state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        case (state)
            ST_IDLE: ready = 1'b1;
            ST_INIT: busy  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Fill row counter. It advances only while filling, and it clears after the last row.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)               cnt <= '0;
        else if (state == ST_INIT) cnt <= last_row ? '0 : cnt + 1'b1;
    end

    // Storage: either the fill clears row cnt in every bank, or the addressed bank/row is
    // written with byte enables. No write can be accepted during the fill, so the two never overlap.
    always_ff @(posedge i_clk) begin
        if (state == ST_INIT) begin
            for (int b = 0; b < NUM_BANK; b++) mem[b][cnt] <= '0;
        end else if (wr) begin
            for (int k = 0; k < NUM_BYTE; k++)
                if (bus.i_ben[k]) mem[bank][row][8*k +: 8] <= bus.i_data[8*k +: 8];
        end
    end

    // Read sample: only the selected bank's read register loads. Each bank register
    // holds its last value, so the registered bank index can drive the output mux.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int b = 0; b < NUM_BANK; b++) bank_rd[b] <= '0;
            bank_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd;
            if (rd) begin
                bank_q <= bank;
                for (int b = 0; b < NUM_BANK; b++)
                    if (bank == BW_BANK'(b)) bank_rd[b] <= mem[b][row];
            end
        end
    end

    assign rd_mux = bank_rd[bank_q];

`ifdef SPSRAM_BANKED_OREG_EN
    logic                oreg_valid;
    logic [BW_DATA-1:0]  oreg_data;

    // Second output stage: it loads only on valid data, so o_data holds between reads.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            oreg_valid <= 1'b0;
            oreg_data  <= '0;
        end else begin
            oreg_valid <= rvalid_q;
            if (rvalid_q) oreg_data <= rd_mux;
        end
    end

    assign bus.o_rvalid = oreg_valid;
    assign bus.o_data   = oreg_data;
`else
    assign bus.o_rvalid = rvalid_q;
    assign bus.o_data   = rd_mux;
`endif

    assign bus.o_ready = ready;
    assign bus.o_busy  = busy;
endmodule
